// File: rtl/proc_pkg.sv
// Shared pipeline definitions: opcode values, instruction field positions, NOP word
// and helpers for pulling register fields out of an instruction.
package proc_pkg;

   localparam logic [31:0] NOP = 32'h0000_0000;

   localparam int OP_HI = 31;
   localparam int OP_LO = 27;
   localparam int RD_HI = 26;
   localparam int RD_LO = 22;
   localparam int RS_HI = 21;
   localparam int RS_LO = 17;
   localparam int RT_HI = 16;
   localparam int RT_LO = 12;

   localparam logic [4:0] OP_R    = 5'b00000;
   localparam logic [4:0] OP_J    = 5'b00001;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JAL  = 5'b00011;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SETX = 5'b10101;
   localparam logic [4:0] OP_BEX  = 5'b10110;

   localparam logic [4:0] REG_STATUS = 5'd30;

   // One register-file read port as seen by the hazard compare.
   typedef struct packed {
      logic       vld;
      logic [4:0] idx;
   } src_t;

   function automatic logic [4:0] ir_op(input logic [31:0] ir);
      return ir[OP_HI:OP_LO];
   endfunction

   function automatic logic [4:0] ir_rd(input logic [31:0] ir);
      return ir[RD_HI:RD_LO];
   endfunction

   function automatic logic [4:0] ir_rs(input logic [31:0] ir);
      return ir[RS_HI:RS_LO];
   endfunction

   function automatic logic [4:0] ir_rt(input logic [31:0] ir);
      return ir[RT_HI:RT_LO];
   endfunction

endpackage

// File: rtl/dx_latch_if.sv
// Decode-to-execute boundary: F/D instruction and operands in, DX latch contents and
// the F/D stall request out, plus the flush and multdiv-busy controls.
interface dx_latch_if;

   logic [31:0] fd_pc;
   logic [31:0] fd_ir;
   logic        fd_valid;
   logic [31:0] rf_a;
   logic [31:0] rf_b;
   logic        flush;
   logic        md_busy;
   logic [31:0] dx_pc;
   logic [31:0] dx_ir;
   logic [31:0] dx_a;
   logic [31:0] dx_b;
   logic        dx_valid;
   logic        stall_fd;

   modport master (
      output fd_pc, fd_ir, fd_valid, rf_a, rf_b, flush, md_busy,
      input  dx_pc, dx_ir, dx_a, dx_b, dx_valid, stall_fd
   );

   modport slave (
      input  fd_pc, fd_ir, fd_valid, rf_a, rf_b, flush, md_busy,
      output dx_pc, dx_ir, dx_a, dx_b, dx_valid, stall_fd
   );

endinterface

// File: rtl/dx_hazard.sv
// Load-use detector: flags when the instruction in F/D reads the register that the
// lw sitting in DX has not yet written back. Purely combinational.
module dx_hazard
   import proc_pkg::*;
(
   input  logic [31:0] dx_ir,
   input  logic        dx_valid,
   input  logic [31:0] fd_ir,
   input  logic        fd_valid,
   output logic        load_use
);

   src_t       src_a;
   src_t       src_b;
   logic [4:0] dx_rd;
   logic       dx_is_lw;
   logic       unused_ir_bits;

   assign unused_ir_bits = ^{fd_ir[11:0], dx_ir[21:0]};

   always_comb begin
      src_a = '0;
      src_b = '0;
      unique case (ir_op(fd_ir))
         OP_R: begin
            src_a = '{vld: 1'b1, idx: ir_rs(fd_ir)};
            src_b = '{vld: 1'b1, idx: ir_rt(fd_ir)};
         end
         OP_ADDI, OP_LW: begin
            src_a = '{vld: 1'b1, idx: ir_rs(fd_ir)};
         end
         OP_SW, OP_BNE, OP_BLT: begin
            src_a = '{vld: 1'b1, idx: ir_rs(fd_ir)};
            src_b = '{vld: 1'b1, idx: ir_rd(fd_ir)};
         end
         OP_JR: begin
            src_a = '{vld: 1'b1, idx: ir_rd(fd_ir)};
         end
         OP_BEX: begin
            src_a = '{vld: 1'b1, idx: REG_STATUS};
         end
         default: begin
            src_a = '0;
            src_b = '0;
         end
      endcase
   end

   assign dx_rd    = ir_rd(dx_ir);
   assign dx_is_lw = dx_valid && (ir_op(dx_ir) == OP_LW) && (dx_rd != 5'd0);

   assign load_use = dx_is_lw && fd_valid &&
                     ((src_a.vld && (src_a.idx == dx_rd)) ||
                      (src_b.vld && (src_b.idx == dx_rd)));

endmodule

// File: rtl/dx_latch.sv
// D/X pipeline register: F/D values appear on dx_* one edge after capture; holds while
// md_busy, bubbles on flush or load-use (load-use only when DX_LOADUSE_EN is defined).
module dx_latch
   import proc_pkg::*;
(
   input  logic    clock,
   input  logic    reset,
   dx_latch_if.slave dx
);

   logic [31:0] dx_pc_q, dx_pc_d;
   logic [31:0] dx_ir_q, dx_ir_d;
   logic [31:0] dx_a_q,  dx_a_d;
   logic [31:0] dx_b_q,  dx_b_d;
   logic        dx_valid_q, dx_valid_d;
   logic        load_use;

`ifdef DX_LOADUSE_EN
   dx_hazard u_hazard (
      .dx_ir    (dx_ir_q),
      .dx_valid (dx_valid_q),
      .fd_ir    (dx.fd_ir),
      .fd_valid (dx.fd_valid),
      .load_use (load_use)
   );
`else
   assign load_use = 1'b0;
`endif

   always_comb begin
      dx_pc_d    = dx_pc_q;
      dx_ir_d    = dx_ir_q;
      dx_a_d     = dx_a_q;
      dx_b_d     = dx_b_q;
      dx_valid_d = dx_valid_q;
      // Flush outranks both stall sources: the F/D content is wrong-path anyway.
      if (dx.flush || (!dx.md_busy && load_use)) begin
         dx_pc_d    = 32'h0;
         dx_ir_d    = NOP;
         dx_a_d     = 32'h0;
         dx_b_d     = 32'h0;
         dx_valid_d = 1'b0;
      end else if (!dx.md_busy) begin
         dx_pc_d    = dx.fd_pc;
         dx_ir_d    = dx.fd_ir;
         dx_a_d     = dx.rf_a;
         dx_b_d     = dx.rf_b;
         dx_valid_d = dx.fd_valid;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dx_pc_q    <= 32'h0;
         dx_ir_q    <= NOP;
         dx_a_q     <= 32'h0;
         dx_b_q     <= 32'h0;
         dx_valid_q <= 1'b0;
      end else begin
         dx_pc_q    <= dx_pc_d;
         dx_ir_q    <= dx_ir_d;
         dx_a_q     <= dx_a_d;
         dx_b_q     <= dx_b_d;
         dx_valid_q <= dx_valid_d;
      end
   end

   assign dx.dx_pc    = dx_pc_q;
   assign dx.dx_ir    = dx_ir_q;
   assign dx.dx_a     = dx_a_q;
   assign dx.dx_b     = dx_b_q;
   assign dx.dx_valid = dx_valid_q;
   assign dx.stall_fd = (dx.md_busy || load_use) && !dx.flush;

endmodule

// File: tb/tb_dx_latch.sv
// Directed bench for dx_latch; expectations for the load-use cases follow DX_LOADUSE_EN.
module tb_dx_latch;

   logic clock;
   logic reset;
   int   n_tests;
   int   n_fail;

   dx_latch_if dxif ();

   dx_latch dut (
      .clock (clock),
      .reset (reset),
      .dx    (dxif.slave)
   );

   localparam logic [31:0] I_ADDI   = 32'h2840_0005; // addi r1,r0,5
   localparam logic [31:0] I_LW_R3  = 32'h40C4_0000; // lw r3,0(r2)
   localparam logic [31:0] I_ADD_R3 = 32'h0106_1000; // add r4,r3,r1
   localparam logic [31:0] I_LW_R0  = 32'h4004_0000; // lw r0,0(r2)
   localparam logic [31:0] I_ADD_R0 = 32'h0100_1000; // add r4,r0,r1
   localparam logic [31:0] I_SW_R3  = 32'h38CA_0000; // sw r3,0(r5)
   localparam logic [31:0] I_LW_R30 = 32'h4784_0000; // lw r30,0(r2)
   localparam logic [31:0] I_BEX    = 32'hB000_0000; // bex 0
   localparam logic [31:0] I_J      = 32'h08C6_0000; // j, rd/rs bits happen to be r3
   localparam logic [31:0] NOPW     = 32'h0000_0000;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] a,
                        input logic [31:0] b, input logic vld);
      dxif.fd_pc    = pc;
      dxif.fd_ir    = ir;
      dxif.rf_a     = a;
      dxif.rf_b     = b;
      dxif.fd_valid = vld;
      dxif.flush    = 1'b0;
      dxif.md_busy  = 1'b0;
      #1;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, "_ir"},    dxif.dx_ir, NOPW);
      check({tag, "_pc"},    dxif.dx_pc, 32'h0);
      check({tag, "_a"},     dxif.dx_a, 32'h0);
      check({tag, "_b"},     dxif.dx_b, 32'h0);
      check({tag, "_valid"}, {31'h0, dxif.dx_valid}, 32'h0);
   endtask

   task automatic flush_clear();
      dxif.flush = 1'b1;
      step();
      dxif.flush = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      drive(32'h0, NOPW, 32'h0, 32'h0, 1'b0);
      step();
      step();
      reset = 1'b0;
      check_bubble("reset");

      // Basic capture
      drive(32'h4, I_ADDI, 32'h11, 32'h22, 1'b1);
      check("addi_stall", {31'h0, dxif.stall_fd}, 32'h0);
      step();
      check("addi_ir", dxif.dx_ir, I_ADDI);
      check("addi_pc", dxif.dx_pc, 32'h4);
      check("addi_a", dxif.dx_a, 32'h11);
      check("addi_b", dxif.dx_b, 32'h22);
      check("addi_valid", {31'h0, dxif.dx_valid}, 32'h1);

      // Load-use on add after lw r3
      drive(32'h8, I_LW_R3, 32'h33, 32'h44, 1'b1);
      step();
      check("lw_ir", dxif.dx_ir, I_LW_R3);
      drive(32'hC, I_ADD_R3, 32'h55, 32'h66, 1'b1);
`ifdef DX_LOADUSE_EN
      check("lu_stall", {31'h0, dxif.stall_fd}, 32'h1);
      step();
      check_bubble("lu_bubble");
      check("lu_stall_drop", {31'h0, dxif.stall_fd}, 32'h0);
      step();
`else
      check("lu_stall_off", {31'h0, dxif.stall_fd}, 32'h0);
      step();
`endif
      check("lu_add_ir", dxif.dx_ir, I_ADD_R3);
      check("lu_add_pc", dxif.dx_pc, 32'hC);
      check("lu_add_a", dxif.dx_a, 32'h55);

      // lw to r0 never stalls
      drive(32'h10, I_LW_R0, 32'h0, 32'h0, 1'b1);
      step();
      drive(32'h14, I_ADD_R0, 32'h77, 32'h88, 1'b1);
      check("r0_stall", {31'h0, dxif.stall_fd}, 32'h0);
      step();
      check("r0_ir", dxif.dx_ir, I_ADD_R0);
      check("r0_pc", dxif.dx_pc, 32'h14);

      // md_busy hold for three edges
      drive(32'h18, I_ADDI, 32'h99, 32'hAA, 1'b1);
      dxif.md_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("md_stall", {31'h0, dxif.stall_fd}, 32'h1);
         step();
         check("md_hold_ir", dxif.dx_ir, I_ADD_R0);
         check("md_hold_pc", dxif.dx_pc, 32'h14);
         check("md_hold_a", dxif.dx_a, 32'h77);
      end
      dxif.md_busy = 1'b0;
      #1;
      check("md_rel_stall", {31'h0, dxif.stall_fd}, 32'h0);
      step();
      check("md_rel_ir", dxif.dx_ir, I_ADDI);
      check("md_rel_pc", dxif.dx_pc, 32'h18);

      // flush beats md_busy and load-use
      drive(32'h1C, I_LW_R3, 32'h0, 32'h0, 1'b1);
      step();
      drive(32'h20, I_ADD_R3, 32'h1, 32'h2, 1'b1);
      dxif.md_busy = 1'b1;
      dxif.flush   = 1'b1;
      #1;
      check("fl_stall", {31'h0, dxif.stall_fd}, 32'h0);
      step();
      check_bubble("fl_bubble");

      // fd_valid=0: loads but never triggers load-use
      drive(32'h24, I_LW_R3, 32'h0, 32'h0, 1'b1);
      step();
      drive(32'h28, I_ADD_R3, 32'h3, 32'h4, 1'b0);
      check("nv_stall", {31'h0, dxif.stall_fd}, 32'h0);
      step();
      check("nv_ir", dxif.dx_ir, I_ADD_R3);
      check("nv_pc", dxif.dx_pc, 32'h28);
      check("nv_valid", {31'h0, dxif.dx_valid}, 32'h0);

      // Reset in the middle of a hold
      drive(32'h2C, I_LW_R3, 32'h0, 32'h0, 1'b1);
      step();
      drive(32'h30, I_ADD_R3, 32'h5, 32'h6, 1'b1);
      dxif.md_busy = 1'b1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      dxif.md_busy = 1'b0;
      check_bubble("rst_mid");
      #1;
      check("rst_stall", {31'h0, dxif.stall_fd}, 32'h0);
      step();
      check("rst_ir", dxif.dx_ir, I_ADD_R3);
      check("rst_pc", dxif.dx_pc, 32'h30);

      // Source decode: sw reads rd, bex reads r30, j reads nothing
      drive(32'h34, I_LW_R3, 32'h0, 32'h0, 1'b1);
      step();
      drive(32'h38, I_SW_R3, 32'h0, 32'h0, 1'b1);
`ifdef DX_LOADUSE_EN
      check("sw_stall", {31'h0, dxif.stall_fd}, 32'h1);
`else
      check("sw_stall_off", {31'h0, dxif.stall_fd}, 32'h0);
`endif
      drive(32'h38, I_J, 32'h0, 32'h0, 1'b1);
      check("j_stall", {31'h0, dxif.stall_fd}, 32'h0);
      flush_clear();
      drive(32'h3C, I_LW_R30, 32'h0, 32'h0, 1'b1);
      step();
      drive(32'h40, I_BEX, 32'h0, 32'h0, 1'b1);
`ifdef DX_LOADUSE_EN
      check("bex_stall", {31'h0, dxif.stall_fd}, 32'h1);
`else
      check("bex_stall_off", {31'h0, dxif.stall_fd}, 32'h0);
`endif
      flush_clear();
      check_bubble("final_flush");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
